// File: rtl/game_pkg.sv
// Shared game constants: grid geometry, lane colours and the hit-flash state encoding.
// Imported by every pixel-side renderer.
package game_pkg;

  localparam int GRID_COLS          = 20;
  localparam int GRID_ROWS          = 15;
  localparam int TILE_SHIFT_DEFAULT = 5;

  localparam logic [8:0] COLOR_GOAL  = 9'b000_111_000;
  localparam logic [8:0] COLOR_START = 9'b010_010_010;
  localparam logic [8:0] COLOR_ROAD  = 9'b001_001_001;
  localparam logic [8:0] COLOR_NONE  = 9'b000_000_000;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FLASH  = 1'b1
  } flash_state_t;

  // True when an in-tile offset lies inside the opaque square, clear of the inset.
  function automatic logic in_inset(input int off, input int border, input int tile_px);
    return (off >= border) && (off <= tile_px - 1 - border);
  endfunction

endpackage

// File: rtl/player_renderer_if.sv
// Scan-position, player-state and composited-pixel signals of the player renderer.
// The producer side (sync generator / movement block / pins) uses master.
interface player_renderer_if;

  logic [9:0] i_col;
  logic [9:0] i_row;
  logic       i_active;
  logic       i_frame_start;
  logic [4:0] i_player_x;
  logic [3:0] i_player_y;
  logic [8:0] i_player_color;
  logic       i_hit;
  logic [8:0] o_rgb;
  logic       o_active;
  logic       o_flashing;

  modport master (
    output i_col, i_row, i_active, i_frame_start,
    output i_player_x, i_player_y, i_player_color, i_hit,
    input  o_rgb, o_active, o_flashing
  );

  modport slave (
    input  i_col, i_row, i_active, i_frame_start,
    input  i_player_x, i_player_y, i_player_color, i_hit,
    output o_rgb, o_active, o_flashing
  );

endinterface

// File: rtl/pixel_to_tile.sv
// First pipeline stage of a tile renderer: scan position to tile index plus in-tile offset.
// Also delays the active qualifier so it stays aligned with the tile coordinates.
module pixel_to_tile
  import game_pkg::*;
#(
  parameter int TILE_SHIFT = TILE_SHIFT_DEFAULT
) (
  input  logic                  i_Clk,
  input  logic                  i_reset,
  input  logic [9:0]            col,
  input  logic [9:0]            row,
  input  logic                  active,
  output logic [9-TILE_SHIFT:0] tile_c_r,
  output logic [9-TILE_SHIFT:0] tile_r_r,
  output logic [TILE_SHIFT-1:0] ox_r,
  output logic [TILE_SHIFT-1:0] oy_r,
  output logic                  active_r
);

  // Stage-1 register: split column/row into tile index and offset.
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      tile_c_r <= '0;
      tile_r_r <= '0;
      ox_r     <= '0;
      oy_r     <= '0;
      active_r <= 1'b0;
    end else begin
      tile_c_r <= col[9:TILE_SHIFT];
      tile_r_r <= row[9:TILE_SHIFT];
      ox_r     <= col[TILE_SHIFT-1:0];
      oy_r     <= row[TILE_SHIFT-1:0];
      active_r <= active;
    end
  end

endmodule

// File: rtl/player_renderer.sv
// Composites the player sprite over the lane background, two cycles behind the scan position.
// Player position/colour are latched once per frame; a hit starts a frame-counted flash.
module player_renderer
  import game_pkg::*;
#(
  parameter int TILE_SHIFT      = TILE_SHIFT_DEFAULT,
  parameter int BORDER          = 4,
  parameter int PLAYER_ORIGIN_X = 11,
  parameter int PLAYER_ORIGIN_Y = 14,
  parameter int FLASH_FRAMES    = 60,
  parameter int FLASH_PERIOD    = 8
) (
  input logic              i_Clk,
  input logic              i_reset,
  player_renderer_if.slave bus
);

  localparam int TW      = 10 - TILE_SHIFT;
  localparam int CW      = $clog2(FLASH_FRAMES);
  localparam int VIS_BIT = $clog2(FLASH_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [4:0]            x_r;
  logic [3:0]            y_r;
  logic [8:0]            color_r;
  flash_state_t          state_r, state_n;
  logic [CW-1:0]         cnt_r, cnt_n;
  logic                  flashing_r;
  logic [TW-1:0]         tile_c_r, tile_r_r;
  logic [TILE_SHIFT-1:0] ox_r, oy_r;
  logic                  active_s1_r;
  logic                  visible_s, hit_s;
  logic [8:0]            bg_s, pix_s;
  logic [8:0]            rgb_r;
  logic                  active_s2_r;

  pixel_to_tile #(.TILE_SHIFT(TILE_SHIFT)) u_pixel_to_tile (
    .i_Clk    (i_Clk),
    .i_reset  (i_reset),
    .col      (bus.i_col),
    .row      (bus.i_row),
    .active   (bus.i_active),
    .tile_c_r (tile_c_r),
    .tile_r_r (tile_r_r),
    .ox_r     (ox_r),
    .oy_r     (oy_r),
    .active_r (active_s1_r)
  );

  // Frame latch: rendering sees only values captured at frame start.
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      x_r     <= 5'(PLAYER_ORIGIN_X);
      y_r     <= 4'(PLAYER_ORIGIN_Y);
      color_r <= 9'd0;
    end else if (bus.i_frame_start) begin
      x_r     <= bus.i_player_x;
      y_r     <= bus.i_player_y;
      color_r <= bus.i_player_color;
    end else begin
      x_r     <= x_r;
      y_r     <= y_r;
      color_r <= color_r;
    end
  end

  // Flash FSM next state; a hit outranks a coincident frame start.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    if (bus.i_hit) begin
      state_n = ST_FLASH;
      cnt_n   = '0;
    end else begin
      case (state_r)
        ST_FLASH: begin
          if (bus.i_frame_start && (cnt_r == CNT_LAST)) begin
            state_n = ST_NORMAL;
            cnt_n   = '0;
          end else if (bus.i_frame_start) begin
            cnt_n = cnt_r + CNT_ONE;
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_NORMAL: begin
          state_n = ST_NORMAL;
          cnt_n   = cnt_r;
        end
        default: begin
          state_n = ST_NORMAL;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Flash FSM state register.
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      state_r    <= ST_NORMAL;
      cnt_r      <= '0;
      flashing_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      flashing_r <= (state_n == ST_FLASH);
    end
  end

  // Hit test at full integer width so x=0 cannot alias onto the last tile.
  always_comb begin
    visible_s = 1'b1;
    hit_s     = 1'b0;
    bg_s      = COLOR_NONE;
    pix_s     = COLOR_NONE;
    if (state_r == ST_FLASH) begin
      visible_s = ~cnt_r[VIS_BIT];
    end else begin
      visible_s = 1'b1;
    end
    hit_s = visible_s
         && (int'(x_r) >= 1) && (int'(x_r) <= GRID_COLS)
         && (int'(y_r) <= GRID_ROWS - 1)
         && (int'(tile_c_r) + 1 == int'(x_r))
         && (int'(tile_r_r) == int'(y_r))
         && in_inset(int'(ox_r), BORDER, 1 << TILE_SHIFT)
         && in_inset(int'(oy_r), BORDER, 1 << TILE_SHIFT);
    if (int'(tile_r_r) == 0) begin
      bg_s = COLOR_GOAL;
    end else if (int'(tile_r_r) == GRID_ROWS - 1) begin
      bg_s = COLOR_START;
    end else if (int'(tile_r_r) < GRID_ROWS - 1) begin
      bg_s = COLOR_ROAD;
    end else begin
      bg_s = COLOR_NONE;
    end
    if (!active_s1_r) begin
      pix_s = COLOR_NONE;
    end else if (hit_s) begin
      pix_s = color_r;
    end else begin
      pix_s = bg_s;
    end
  end

  // Stage-2 output register.
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      rgb_r       <= 9'd0;
      active_s2_r <= 1'b0;
    end else begin
      rgb_r       <= pix_s;
      active_s2_r <= active_s1_r;
    end
  end

  assign bus.o_rgb      = rgb_r;
  assign bus.o_active   = active_s2_r;
  assign bus.o_flashing = flashing_r;

endmodule

// File: tb/tb_player_renderer.sv
// Self-checking bench for player_renderer: table of pixel vectors plus flash/reset sequences,
// with pixel expectations queued at drive time and compared when they emerge two cycles later.
module tb_player_renderer;

  localparam logic [8:0] C_GOAL  = 9'b000_111_000;
  localparam logic [8:0] C_START = 9'b010_010_010;
  localparam logic [8:0] C_ROAD  = 9'b001_001_001;
  localparam logic [8:0] C_P     = 9'b000_000_111;

  typedef struct {
    logic [8:0] rgb;
    logic       act;
    bit         chk;
    string      nm;
  } exp_t;

  typedef struct {
    int         col;
    int         row;
    logic       act;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  vec_t tbl[13];

  always #5 clk = ~clk;

  player_renderer_if bus ();

  player_renderer dut (
    .i_Clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic chk_val(input string nm, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h expected %03h", nm, got, exp);
    end
  endtask

  // One clock: drive inputs, queue the expectation, compare whatever emerges now.
  task automatic step(input int c, input int r, input logic a, input logic fs, input logic h,
                      input logic [8:0] exp, input bit chk, input string nm);
    exp_t e;
    bus.i_col         = 10'(c);
    bus.i_row         = 10'(r);
    bus.i_active      = a;
    bus.i_frame_start = fs;
    bus.i_hit         = h;
    e.rgb = a ? exp : 9'd0;
    e.act = a;
    e.chk = chk;
    e.nm  = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.i_frame_start = 1'b0;
    bus.i_hit         = 1'b0;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      if (e.chk) chk_val(e.nm, {bus.o_active, bus.o_rgb}, {e.act, e.rgb});
    end
  endtask

  task automatic check_pix(input int c, input int r, input logic [8:0] exp, input string nm);
    step(c, r, 1'b1, 1'b0, 1'b0, exp, 1'b1, nm);
  endtask

  task automatic frame_pulse(input logic h);
    step(0, 0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, "flush");
    step(0, 0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, "flush");
    step(0, 0, 1'b0, 1'b1, h, 9'd0, 1'b0, "fs");
  endtask

  initial begin
    tbl[0]  = '{324, 420, 1'b1, C_P};
    tbl[1]  = '{323, 420, 1'b1, C_ROAD};
    tbl[2]  = '{10,  5,   1'b1, C_GOAL};
    tbl[3]  = '{347, 443, 1'b1, C_P};
    tbl[4]  = '{348, 420, 1'b1, C_ROAD};
    tbl[5]  = '{351, 447, 1'b1, C_ROAD};
    tbl[6]  = '{324, 452, 1'b1, C_START};
    tbl[7]  = '{324, 420, 1'b0, 9'd0};
    tbl[8]  = '{639, 479, 1'b1, C_START};
    tbl[9]  = '{352, 420, 1'b1, C_ROAD};
    tbl[10] = '{292, 420, 1'b1, C_ROAD};
    tbl[11] = '{324, 404, 1'b1, C_ROAD};
    tbl[12] = '{10,  500, 1'b1, 9'd0};

    bus.i_col = 10'd0; bus.i_row = 10'd0; bus.i_active = 1'b0;
    bus.i_frame_start = 1'b0; bus.i_hit = 1'b0;
    bus.i_player_x = 5'd3; bus.i_player_y = 4'd5; bus.i_player_color = 9'h1ff;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_val("reset_rgb_active", {bus.o_active, bus.o_rgb}, 10'd0);
    chk_val("reset_flashing", {9'd0, bus.o_flashing}, 10'd0);
    rst = 1'b0;

    // Origin latch (11,14), colour 0; neighbours bracket the 2-cycle latency.
    check_pix(323, 452, C_START, "origin_border");
    check_pix(324, 452, 9'd0, "origin_player");
    check_pix(323, 452, C_START, "origin_border2");
    check_pix(356, 452, C_START, "origin_next_tile");

    // Table of pixels against latch (11,13).
    bus.i_player_x = 5'd11; bus.i_player_y = 4'd13; bus.i_player_color = C_P;
    frame_pulse(1'b0);
    for (int i = 0; i < 13; i++)
      step(tbl[i].col, tbl[i].row, tbl[i].act, 1'b0, 1'b0, tbl[i].exp, 1'b1, $sformatf("tbl%0d", i));

    // Mid-frame position change is invisible until the next frame start.
    bus.i_player_x = 5'd12;
    check_pix(356, 420, C_ROAD, "midframe_hold");
    check_pix(324, 420, C_P, "midframe_old");
    frame_pulse(1'b0);
    check_pix(356, 420, C_P, "next_frame_new");
    check_pix(324, 420, C_ROAD, "next_frame_old");

    // Out-of-range latches never match and never alias.
    bus.i_player_x = 5'd0; bus.i_player_y = 4'd0;
    frame_pulse(1'b0);
    for (int t = 0; t < 20; t++) check_pix(t * 32 + 4, 4, C_GOAL, $sformatf("x0_tile%0d", t));
    check_pix(620, 10, C_GOAL, "x0_tile19_alias");
    bus.i_player_x = 5'd21;
    frame_pulse(1'b0);
    check_pix(644, 4, C_GOAL, "x21_no_match");
    bus.i_player_x = 5'd11; bus.i_player_y = 4'd15;
    frame_pulse(1'b0);
    check_pix(324, 484, 9'd0, "y15_no_match");

    // Full flash sequence.
    bus.i_player_y = 4'd13;
    frame_pulse(1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b1, 9'd0, 1'b0, "hit");
    for (int f = 0; f < 60; f++) begin
      check_pix(324, 420, (((f / 8) % 2) == 0) ? C_P : C_ROAD, $sformatf("flashA_f%0d", f));
      chk_val($sformatf("flashingA_f%0d", f), {9'd0, bus.o_flashing}, 10'd1);
      frame_pulse(1'b0);
    end
    chk_val("flash_done", {9'd0, bus.o_flashing}, 10'd0);
    check_pix(324, 420, C_P, "flash_done_visible");

    // Restart: hit coincident with frame start at frame 20.
    step(0, 0, 1'b0, 1'b0, 1'b1, 9'd0, 1'b0, "hitB");
    for (int f = 0; f < 20; f++) frame_pulse(1'b0);
    check_pix(324, 420, C_P, "flashB_f20");
    bus.i_player_x = 5'd12;
    frame_pulse(1'b1);
    chk_val("restart_flashing", {9'd0, bus.o_flashing}, 10'd1);
    check_pix(324, 420, C_ROAD, "restart_latched_old");
    for (int f = 0; f < 30; f++) begin
      check_pix(356, 420, (((f / 8) % 2) == 0) ? C_P : C_ROAD, $sformatf("flashB_r%0d", f));
      frame_pulse(1'b0);
    end
    check_pix(356, 420, C_ROAD, "flashB_r30");
    step(0, 0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, "flush");
    chk_val("pre_reset_flashing", {9'd0, bus.o_flashing}, 10'd1);

    // Reset during FLASH, together with a hit: reset wins.
    bus.i_col = 10'd356; bus.i_row = 10'd420; bus.i_active = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.i_hit = 1'b1;
    @(posedge clk);
    #1;
    chk_val("rst_rgb_active", {bus.o_active, bus.o_rgb}, 10'd0);
    chk_val("rst_flashing", {9'd0, bus.o_flashing}, 10'd0);
    rst = 1'b0;
    bus.i_hit = 1'b0;
    exp_q.delete();
    check_pix(323, 452, C_START, "post_rst_border");
    check_pix(324, 452, 9'd0, "post_rst_origin");
    check_pix(356, 452, C_START, "post_rst_next");
    step(0, 0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, "flush");
    step(0, 0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, "flush");
    chk_val("post_rst_flashing", {9'd0, bus.o_flashing}, 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
